// File: rtl/mm_host_mem_pkg.sv
// Shared line geometry and mm_if transaction types for the main-memory host.
package mm_host_mem_pkg;

    localparam int MM_LINE_W        = 128;
    localparam int MM_LINE_OFFSET_W = 4;
    localparam int MM_ADDR_W        = 32;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [MM_ADDR_W-1:0] addr;
        logic [MM_LINE_W-1:0] wdata;
    } mm_req_t;

    typedef struct packed {
        logic                 valid;
        logic [MM_LINE_W-1:0] rdata;
    } mm_res_t;

endpackage

// File: rtl/mm_if.sv
// mm_if: request slots from clients, matching response slots and a host ready flag.
interface mm_if #(
    parameter int NUM_OF_REQS = 4,
    parameter int NUM_OF_RES  = 4
);
    import mm_host_mem_pkg::*;

    mm_req_t [NUM_OF_REQS-1:0] req;
    mm_res_t [NUM_OF_RES-1:0]  res;
    logic                      ready;

    modport host   (input req, output res, output ready);
    modport client (output req, input res, input ready);

endinterface

// File: rtl/mm_host_mem_rr_arbiter.sv
// rr_arbiter: picks the first asserted request at or after ptr, wrapping modulo NUM.
module rr_arbiter #(
    parameter int NUM = 4,
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [NUM-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    // Scan farthest-first so the candidate nearest to ptr is the last to win.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (req[IDX_W'((int'(ptr) + i) % NUM)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'((int'(ptr) + i) % NUM);
            end
        end
    end

endmodule

// File: rtl/mm_host_mem.sv
// mm_host_mem: main-memory responder for mm_if; round-robin over request slots, one access in flight.
// Define MM_HOST_STALL_INJECT_EN to add LFSR-driven ready stalls while idle.
module mm_host_mem
    import mm_host_mem_pkg::*;
#(
    parameter int NUM_OF_REQS = 4,
    parameter int NUM_OF_RES  = 4,
    parameter int DEPTH_LINES = 4096,
    parameter int LATENCY     = 4
) (
    input logic clk,
    input logic rst,
    mm_if.host  mm
);

    localparam int IDX_W      = (NUM_OF_REQS > 1) ? $clog2(NUM_OF_REQS) : 1;
    localparam int LINE_IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                      we_q, we_d;
    logic [LINE_IDX_W-1:0]     line_q, line_d;
    logic [MM_LINE_W-1:0]      wdata_q, wdata_d;
    mm_res_t [NUM_OF_RES-1:0]  res_q, res_d;
    logic                      ready_q, ready_d;
    logic                      mem_we;
    logic                      stall_d;

    logic [MM_LINE_W-1:0]      mem_q [DEPTH_LINES];

    logic [NUM_OF_REQS-1:0]    req_vld;
    logic                      gnt_vld;
    logic [IDX_W-1:0]          gnt_idx;
    mm_req_t                   gnt_req;

    always_comb begin
        for (int i = 0; i < NUM_OF_REQS; i++) begin
            req_vld[i] = mm.req[i].valid;
        end
    end

    assign gnt_req = mm.req[gnt_idx];

    rr_arbiter #(.NUM(NUM_OF_REQS)) u_arb (
        .req       (req_vld),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_vld),
        .gnt_idx   (gnt_idx)
    );

`ifdef MM_HOST_STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end

    // ready is registered, so the stall decision uses the LFSR value that will be current next cycle.
    assign stall_d = (lfsr_d[1:0] == 2'b00);
`else
    assign stall_d = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        we_d     = we_q;
        line_d   = line_q;
        wdata_d  = wdata_q;
        res_d    = '0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready_q && gnt_vld && gnt_req.valid) begin
                    idx_d   = gnt_idx;
                    we_d    = gnt_req.we;
                    line_d  = LINE_IDX_W'(gnt_req.addr >> MM_LINE_OFFSET_W);
                    wdata_d = gnt_req.wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    mem_we              = we_q;
                    res_d[idx_q].valid  = 1'b1;
                    res_d[idx_q].rdata  = we_q ? wdata_q : mem_q[line_q];
                    state_d             = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rr_ptr_d = (idx_q == IDX_W'(NUM_OF_REQS - 1)) ? '0 : idx_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) && !stall_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            line_q   <= '0;
            wdata_q  <= '0;
            res_q    <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            line_q   <= line_d;
            wdata_q  <= wdata_d;
            res_q    <= res_d;
            ready_q  <= ready_d;
        end
    end

    // Memory contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[line_q] <= wdata_q;
    end

    assign mm.res   = res_q;
    assign mm.ready = ready_q;

endmodule
